// File: rtl/sha512_pkg.sv
// Shared widths, pad byte and FSM state type for the SHA-512 padder.
// SHA512_PADDER_LEN128_EN selects a 128-bit byte counter (default 64-bit).
package sha512_pkg;
   localparam int WORD_W  = 64;
   localparam int CHUNK_W = 1024;
   localparam int WORDS   = 16;
   localparam logic [7:0] PAD_BYTE = 8'h80;
`ifdef SHA512_PADDER_LEN128_EN
   localparam int CNT_W = 128;
`else
   localparam int CNT_W = 64;
`endif
   typedef enum logic [1:0] {FILL, PAD, EMIT, EXTRA} state_t;
endpackage

// File: rtl/sha512_pad_word.sv
// Last-word masking: keeps the first 'bytes' bytes, appends 0x80 if room.
// Bytes after the marker are zeroed.
module sha512_pad_word
   import sha512_pkg::*;
(
   input  logic [WORD_W-1:0] data,
   input  logic [3:0]        bytes,
   output logic [WORD_W-1:0] word
);
   always_comb begin
      word = '0;
      for (int i = 0; i < 8; i++) begin
         if (4'(i) < bytes)
            word[WORD_W-1-8*i -: 8] = data[WORD_W-1-8*i -: 8];
         else if (4'(i) == bytes)
            word[WORD_W-1-8*i -: 8] = PAD_BYTE;
      end
   end
endmodule

// File: rtl/sha512_padder.sv
// SHA-512 message padder: 64-bit words in, padded 1024-bit chunks out.
// SHA512_PADDER_LEN128_EN widens the byte counter to the full 128 bits.
module sha512_padder
   import sha512_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic [WORD_W-1:0]   in_data,
   input  logic                in_valid,
   input  logic                in_last,
   input  logic [3:0]          in_bytes,
   output logic                in_ready,
   output logic [CHUNK_W-1:0]  chunk,
   output logic                chunk_valid,
   output logic                chunk_first,
   output logic                chunk_last,
   input  logic                chunk_ready
);
   state_t            state;
   logic [3:0]        w_idx;
   logic [3:0]        last_bytes;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  len;
   logic              extra_pending;
   logic              pad_start_pending;
   logic [WORD_W-1:0] words_q [WORDS];
   logic [WORD_W-1:0] pad_w;
   logic [WORD_W-1:0] len_hi;
   logic [WORD_W-1:0] len_lo;
   logic [4:0]        mark_idx;
   logic              full_word;
   logic              fits;
   logic              take;

   assign take      = in_valid && in_ready;
   assign full_word = (last_bytes == 4'd8);
   // Word index receiving the 0x80 marker; 16 means no room at all.
   assign mark_idx  = {1'b0, w_idx} + 5'(full_word);
   assign fits      = (mark_idx <= 5'd13);
   assign len       = cnt << 3;
`ifdef SHA512_PADDER_LEN128_EN
   assign len_hi    = len[CNT_W-1 -: WORD_W];
`else
   assign len_hi    = '0;
`endif
   assign len_lo    = len[WORD_W-1:0];

   sha512_pad_word u_pad (
      .data  (words_q[w_idx]),
      .bytes (last_bytes),
      .word  (pad_w)
   );

   always_ff @(posedge clk) begin
      case (state)
         FILL: if (take) words_q[w_idx] <= in_data;
         PAD: begin
            for (int j = 0; j < WORDS; j++) begin
               if (5'(j) == {1'b0, w_idx})
                  words_q[j] <= pad_w;
               else if (5'(j) > {1'b0, w_idx}) begin
                  if (fits && j == 14)
                     words_q[j] <= len_hi;
                  else if (fits && j == 15)
                     words_q[j] <= len_lo;
                  else if (5'(j) == mark_idx)
                     words_q[j] <= {PAD_BYTE, 56'd0};
                  else
                     words_q[j] <= '0;
               end
            end
         end
         EXTRA: begin
            for (int j = 0; j < WORDS; j++) begin
               if (j == 14)
                  words_q[j] <= len_hi;
               else if (j == 15)
                  words_q[j] <= len_lo;
               else if (j == 0 && pad_start_pending)
                  words_q[j] <= {PAD_BYTE, 56'd0};
               else
                  words_q[j] <= '0;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      chunk = '0;
      for (int j = 0; j < WORDS; j++)
         chunk[CHUNK_W-1-WORD_W*j -: WORD_W] = words_q[j];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state             <= FILL;
         w_idx             <= '0;
         last_bytes        <= '0;
         cnt               <= '0;
         extra_pending     <= 1'b0;
         pad_start_pending <= 1'b0;
         chunk_first       <= 1'b1;
         chunk_valid       <= 1'b0;
         chunk_last        <= 1'b0;
         in_ready          <= 1'b0;
      end else begin
         unique case (state)
            FILL: begin
               in_ready <= 1'b1;
               if (take) begin
                  cnt <= cnt + (in_last ? CNT_W'(in_bytes) : CNT_W'(8));
                  if (in_last) begin
                     last_bytes <= in_bytes;
                     in_ready   <= 1'b0;
                     state      <= PAD;
                  end else begin
                     w_idx <= w_idx + 4'd1;
                     if (w_idx == 4'd15) begin
                        in_ready    <= 1'b0;
                        chunk_valid <= 1'b1;
                        chunk_last  <= 1'b0;
                        state       <= EMIT;
                     end
                  end
               end
            end
            PAD: begin
               chunk_valid <= 1'b1;
               state       <= EMIT;
               if (full_word && w_idx == 4'd15) begin
                  pad_start_pending <= 1'b1;
                  chunk_last        <= 1'b0;
               end else if (fits) begin
                  chunk_last <= 1'b1;
               end else begin
                  extra_pending <= 1'b1;
                  chunk_last    <= 1'b0;
               end
            end
            EMIT: begin
               if (chunk_ready) begin
                  chunk_valid <= 1'b0;
                  chunk_last  <= 1'b0;
                  chunk_first <= chunk_last;
                  if (chunk_last) cnt <= '0;
                  if (extra_pending || pad_start_pending) begin
                     state <= EXTRA;
                  end else begin
                     w_idx    <= '0;
                     in_ready <= 1'b1;
                     state    <= FILL;
                  end
               end
            end
            EXTRA: begin
               extra_pending     <= 1'b0;
               pad_start_pending <= 1'b0;
               chunk_last        <= 1'b1;
               chunk_valid       <= 1'b1;
               state             <= EMIT;
            end
         endcase
      end
   end
endmodule
